low_band_fir: RTL and testbench

//   Stereo multiply-accumulate FIR for the low band of the equalizer. Consumes the
//   1-cycle-latency RAM sample stream and the 'sequencing' window from the low-freq

---
 rtl/eq_pkg.sv | 23 ++
 rtl/coeff_rom_1024x16.sv | 18 +
 rtl/low_band_fir.sv | 104 ++++++++++
 tb/tb_low_band_fir.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/eq_pkg.sv
// Shared equalizer constants and helpers.
// Used by every band filter in the equalizer.
package eq_pkg;
  localparam int SMPL_W  = 16;
  localparam int COEFF_W = 16;
  localparam int PROD_W  = 32;
  localparam int Q_SHIFT = 15;
  localparam int ADDR_W  = 10;

  localparam logic signed [SMPL_W-1:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [SMPL_W-1:0] SAT_MIN = 16'sh8000;

  function automatic logic signed [SMPL_W-1:0] sat16(
    input logic signed [63:0] v
  );
    if (v > 64'(SAT_MAX))
      return SAT_MAX;
    else if (v < 64'(SAT_MIN))
      return SAT_MIN;
    else
      return v[SMPL_W-1:0];
  endfunction
endpackage

// File: rtl/coeff_rom_1024x16.sv
// Synchronous-read coefficient ROM, 1024 x 16b Q1.15.
// Contents are written into mem by the enclosing environment.
module coeff_rom_1024x16
  import eq_pkg::*;
#(
  parameter string COEFF_FILE = "low_band_coeff.hex"
) (
  input  logic                      clk,
  input  logic [ADDR_W-1:0]         addr,
  output logic signed [COEFF_W-1:0] data
);

  logic [COEFF_W-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk)
    data <= mem[addr];

endmodule

// File: rtl/low_band_fir.sv
// Stereo low-band MAC FIR: one filtered L/R pair per
// sequencing window, shared coefficient ROM and control.
module low_band_fir
  import eq_pkg::*;
#(
  parameter string COEFF_FILE = "low_band_coeff.hex",
  parameter int    ACC_W      = 42
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sequencing,
  input  logic signed [SMPL_W-1:0] lft_smpl,
  input  logic signed [SMPL_W-1:0] rght_smpl,
  output logic signed [SMPL_W-1:0] lft_filt,
  output logic signed [SMPL_W-1:0] rght_filt,
  output logic                     filt_vld
);

  logic [ADDR_W-1:0]         coeff_addr;
  logic signed [COEFF_W-1:0] coeff;
  logic                      seq_d1;
  logic                      seq_d2;
  logic                      seq_d3;
  logic                      first_tap;
  logic                      done;
  logic signed [PROD_W-1:0]  lft_prod;
  logic signed [PROD_W-1:0]  rght_prod;
  logic signed [ACC_W-1:0]   lft_acc;
  logic signed [ACC_W-1:0]   rght_acc;

  coeff_rom_1024x16 #(
    .COEFF_FILE(COEFF_FILE)
  ) u_rom (
    .clk (clk),
    .addr(coeff_addr),
    .data(coeff)
  );

  // Idle cycles park the address so each window starts at coeff[0].
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      coeff_addr <= '0;
    else if (sequencing)
      coeff_addr <= coeff_addr + 1'b1;
    else
      coeff_addr <= '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_d1 <= 1'b0;
      seq_d2 <= 1'b0;
      seq_d3 <= 1'b0;
    end else begin
      seq_d1 <= sequencing;
      seq_d2 <= seq_d1;
      seq_d3 <= seq_d2;
    end
  end

  assign first_tap = seq_d2 & ~seq_d3;
  assign done      = seq_d3 & ~seq_d2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lft_prod  <= '0;
      rght_prod <= '0;
    end else if (seq_d1) begin
      lft_prod  <= PROD_W'(lft_smpl) * PROD_W'(coeff);
      rght_prod <= PROD_W'(rght_smpl) * PROD_W'(coeff);
    end
  end

  // First tap overwrites, so no separate clear cycle between windows.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lft_acc  <= '0;
      rght_acc <= '0;
    end else if (seq_d2) begin
      if (first_tap) begin
        lft_acc  <= ACC_W'(lft_prod);
        rght_acc <= ACC_W'(rght_prod);
      end else begin
        lft_acc  <= lft_acc + ACC_W'(lft_prod);
        rght_acc <= rght_acc + ACC_W'(rght_prod);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lft_filt  <= '0;
      rght_filt <= '0;
      filt_vld  <= 1'b0;
    end else begin
      filt_vld <= done;
      if (done) begin
        lft_filt  <= sat16(64'(lft_acc >>> Q_SHIFT));
        rght_filt <= sat16(64'(rght_acc >>> Q_SHIFT));
      end
    end
  end

endmodule

// File: tb/tb_low_band_fir.sv
// Self-checking bench for low_band_fir: directed windows plus
// random windows checked cycle by cycle against a window-sum model.
module tb_low_band_fir;

  logic        clk = 1'b0;
  logic        rst;
  logic        sequencing;
  logic [15:0] lft_smpl;
  logic [15:0] rght_smpl;
  logic [15:0] lft_filt;
  logic [15:0] rght_filt;
  logic        filt_vld;

  low_band_fir #(
    .COEFF_FILE(""),
    .ACC_W     (42)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sequencing(sequencing),
    .lft_smpl  (lft_smpl),
    .rght_smpl (rght_smpl),
    .lft_filt  (lft_filt),
    .rght_filt (rght_filt),
    .filt_vld  (filt_vld)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          coeff_m [1024];
  bit          sq [$];
  logic [15:0] lq [$];
  logic [15:0] rq [$];
  logic [15:0] held_l;
  logic [15:0] held_r;

  task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic longint s16(logic [15:0] v);
    logic signed [15:0] t;
    t = v;
    return longint'(t);
  endfunction

  function automatic logic [15:0] sat_ref(longint v);
    if (v > 32767)  return 16'h7FFF;
    if (v < -32768) return 16'h8000;
    return v[15:0];
  endfunction

  task automatic load_rom();
    for (int i = 0; i < 1024; i++)
      dut.u_rom.mem[i] = coeff_m[i][15:0];
  endtask

  task automatic pad();
    while (lq.size() < sq.size()) begin
      lq.push_back(16'($urandom));
      rq.push_back(16'($urandom));
    end
  endtask

  task automatic add_idle(int m);
    repeat (m) sq.push_back(1'b0);
    pad();
  endtask

  // mode 0: constant, 1: random, 2: impulse at tap 5
  task automatic add_window(int n, int mode,
                            logic [15:0] lv, logic [15:0] rv);
    pad();
    lq.push_back(16'($urandom));
    rq.push_back(16'($urandom));
    for (int k = 0; k < n; k++) begin
      sq.push_back(1'b1);
      case (mode)
        0: begin lq.push_back(lv); rq.push_back(rv); end
        1: begin
          lq.push_back(16'($urandom));
          rq.push_back(16'($urandom));
        end
        default: begin
          lq.push_back(k == 5 ? lv : 16'h0000);
          rq.push_back(k == 5 ? rv : 16'h0000);
        end
      endcase
    end
  endtask

  task automatic play(int rst_cyc);
    int          n;
    int          c;
    int          k;
    int          e;
    int          p;
    longint      sl;
    longint      sr;
    bit          ev [];
    logic [15:0] el [];
    logic [15:0] er [];
    add_idle(6);
    n  = sq.size();
    ev = new[n];
    el = new[n];
    er = new[n];
    c  = 0;
    while (c < n) begin
      if (sq[c]) begin
        sl = 0;
        sr = 0;
        k  = 0;
        while (c < n && sq[c]) begin
          sl += s16(lq[c+1]) * longint'(coeff_m[k % 1024]);
          sr += s16(rq[c+1]) * longint'(coeff_m[k % 1024]);
          k++;
          c++;
        end
        e = c - 1;
        p = e + 4;
        if (p < n && !(rst_cyc >= 0 && e < rst_cyc && p > rst_cyc)) begin
          ev[p] = 1'b1;
          el[p] = sat_ref(sl >>> 15);
          er[p] = sat_ref(sr >>> 15);
        end
      end else begin
        c++;
      end
    end
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (ev[i]) begin
        held_l = el[i];
        held_r = er[i];
      end
      check("filt_vld", {15'b0, filt_vld}, {15'b0, ev[i]});
      check("lft_filt", lft_filt, held_l);
      check("rght_filt", rght_filt, held_r);
      sequencing = sq[i];
      lft_smpl   = lq[i];
      rght_smpl  = rq[i];
      if (i == rst_cyc) begin
        rst = 1'b1;
        #1;
        held_l = 16'h0000;
        held_r = 16'h0000;
        check("async_rst_vld", {15'b0, filt_vld}, 16'h0000);
        check("async_rst_lft", lft_filt, 16'h0000);
        check("async_rst_rght", rght_filt, 16'h0000);
        rst = 1'b0;
      end
    end
    sq.delete();
    lq.delete();
    rq.delete();
  endtask

  initial begin
    int r;
    rst        = 1'b1;
    sequencing = 1'b0;
    lft_smpl   = 16'h0000;
    rght_smpl  = 16'h0000;
    held_l     = 16'h0000;
    held_r     = 16'h0000;
    for (int i = 0; i < 1024; i++) coeff_m[i] = 0;
    load_rom();
    repeat (3) @(posedge clk);
    #1;
    check("reset_vld", {15'b0, filt_vld}, 16'h0000);
    check("reset_lft", lft_filt, 16'h0000);
    check("reset_rght", rght_filt, 16'h0000);
    rst = 1'b0;

    coeff_m[5] = 32'h2000;
    load_rom();
    add_idle(2);
    add_window(16, 2, 16'h4000, 16'hC000);
    play(-1);
    check("impulse_lft", lft_filt, 16'h1000);
    check("impulse_rght", rght_filt, 16'hF000);

    for (int i = 0; i < 1024; i++) coeff_m[i] = 16;
    load_rom();
    add_idle(1);
    add_window(1021, 0, 16'h1000, 16'h1000);
    play(-1);
    check("dc_lft", lft_filt, 16'h07FA);
    check("dc_rght", rght_filt, 16'h07FA);

    for (int i = 0; i < 1024; i++) coeff_m[i] = 32767;
    load_rom();
    add_idle(1);
    add_window(1021, 0, 16'h7FFF, 16'h7FFF);
    play(-1);
    check("sat_pos", lft_filt, 16'h7FFF);
    add_idle(1);
    add_window(1021, 0, 16'h8000, 16'h8000);
    play(-1);
    check("sat_neg", rght_filt, 16'h8000);

    for (int i = 0; i < 1024; i++) coeff_m[i] = 16;
    load_rom();
    add_idle(1);
    add_window(1021, 0, 16'h1000, 16'h1000);
    add_idle(1);
    add_window(1021, 0, 16'h0800, 16'h0800);
    play(-1);
    check("b2b_lft", lft_filt, 16'h03FD);

    add_idle(2);
    add_window(500, 0, 16'h1000, 16'h1000);
    r = sq.size();
    add_idle(3);
    add_window(1021, 0, 16'h1000, 16'h1000);
    play(r);
    check("post_rst_dc", lft_filt, 16'h07FA);

    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 1024; i++)
        coeff_m[i] = int'($urandom_range(0, 4095)) - 2048;
      load_rom();
      repeat (6) begin
        add_idle(int'($urandom_range(1, 3)));
        add_window(int'($urandom_range(1, 40)), 1, 16'h0, 16'h0);
      end
      play(-1);
    end

    for (int i = 0; i < 1024; i++)
      coeff_m[i] = int'($urandom_range(0, 255)) - 128;
    load_rom();
    add_idle(1);
    add_window(1030, 1, 16'h0, 16'h0);
    play(-1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
